zigbee_pad_arbiter: RTL and testbench

Round-robin arbiter sharing the 18-bit output pad bus of the Zigbee padded top among several internal requesters (TX chip stream, RX data, status, debug). It sits between the platform's output sources and the output pad ring. Each requester gets the bus for one burst, ended either by its last flag or by a maximum beat count. A 2-bit tag identifying the granted source is driven alongside the data.

---
 rtl/zigbee_pad_arbiter.sv | 143 ++++++++++++++
 tb/tb_zigbee_pad_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/zigbee_pad_arbiter.sv
// zigbee_pad_arbiter
//   Round-robin arbiter that shares the output pad bus of the Zigbee padded
//   top among NREQ internal requesters (TX chip stream, RX data, status,
//   debug). A requester keeps the bus for one burst. The burst ends on an
//   accepted beat that carries last, or on the BURST_MAX-th accepted beat.
//   After each burst there is a one-cycle arbitration bubble.
//
//   Optional build macro:
//     ZIGBEE_PAD_ARB_FIXED_PRIO_EN - fixed priority (lowest valid index
//                                    wins). No round-robin pointer is built.
//
//   Ports:
//     clk_i        clock
//     rst_i        synchronous active-high reset
//     req_valid_i  per-requester beat valid
//     req_data_i   per-requester data, requester k at [k*DW +: DW]
//     req_last_i   per-requester last-beat flag
//     req_ready_o  per-requester ready (only the granted bit can be high)
//     pad_valid_o  beat valid toward the pad ring
//     pad_data_o   beat data toward the pad ring
//     pad_tag_o    index of the granted (or last granted) requester
//     pad_ready_i  pad ring accepts the beat
//     grant_o      one-hot grant, zero while idle
//     busy_o       high while a grant is active
module zigbee_pad_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 18,
   parameter int BURST_MAX = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NREQ-1:0]    req_valid_i,
   input  logic [NREQ*DW-1:0] req_data_i,
   input  logic [NREQ-1:0]    req_last_i,
   output logic [NREQ-1:0]    req_ready_o,
   output logic               pad_valid_o,
   output logic [DW-1:0]      pad_data_o,
   output logic [1:0]         pad_tag_o,
   input  logic               pad_ready_i,
   output logic [NREQ-1:0]    grant_o,
   output logic               busy_o
);

   localparam int CW = $clog2(BURST_MAX + 1);

   typedef enum logic {IDLE, XFER} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [1:0]      start_idx;
   logic [1:0]      pick_idx;
   logic            pick_found;
   logic            sel_valid;
   logic            sel_last;
   logic [DW-1:0]   sel_data;
   logic            accept;
   logic            burst_end;

`ifdef ZIGBEE_PAD_ARB_FIXED_PRIO_EN
   assign start_idx = 2'd0;
`else
   logic [1:0]      ptr;
   assign start_idx = ptr;
`endif

   // pad_tag_o always holds the granted index while in XFER, so it
   // steers the source mux directly.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pad_tag_o == 2'(k)) begin
            sel_valid = req_valid_i[k];
            sel_last  = req_last_i[k];
            sel_data  = req_data_i[k*DW +: DW];
         end
      end
   end

   assign busy_o      = (state == XFER);
   assign pad_valid_o = busy_o & sel_valid;
   assign pad_data_o  = busy_o ? sel_data : '0;
   // grant_o is the one-hot of the granted index, so it doubles as the ready mask
   assign req_ready_o = (busy_o && pad_ready_i) ? grant_o : '0;

   assign accept    = pad_valid_o & pad_ready_i;
   assign burst_end = accept & (sel_last | ((int'(cnt) + 1) == BURST_MAX));

   // Scan from start_idx upward modulo NREQ. The loop runs from the far end
   // back toward start_idx, so the closest valid requester is written last
   // and wins.
   always_comb begin
      int idx;
      idx        = 0;
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = (int'(start_idx) + i) % NREQ;
         if (req_valid_i[idx]) begin
            pick_found = 1'b1;
            pick_idx   = 2'(idx);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         grant_o   <= '0;
         pad_tag_o <= 2'd0;
         cnt       <= '0;
`ifndef ZIGBEE_PAD_ARB_FIXED_PRIO_EN
         ptr       <= 2'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_o   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                  pad_tag_o <= pick_idx;
                  cnt       <= '0;
                  state     <= XFER;
               end
            end
            XFER: begin
               if (burst_end) begin
                  state   <= IDLE;
                  grant_o <= '0;
                  cnt     <= '0;
`ifndef ZIGBEE_PAD_ARB_FIXED_PRIO_EN
                  ptr     <= 2'((int'(pad_tag_o) + 1) % NREQ);
`endif
               end else if (accept) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zigbee_pad_arbiter.sv
module tb_zigbee_pad_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 18;
   localparam int BM   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_last;
   logic [NREQ-1:0]    req_ready_o;
   logic               pad_valid_o;
   logic [DW-1:0]      pad_data_o;
   logic [1:0]         pad_tag_o;
   logic               pad_ready;
   logic [NREQ-1:0]    grant_o;
   logic               busy_o;

   always #5 clk = ~clk;

   zigbee_pad_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BM)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready_o),
      .pad_valid_o (pad_valid_o),
      .pad_data_o  (pad_data_o),
      .pad_tag_o   (pad_tag_o),
      .pad_ready_i (pad_ready),
      .grant_o     (grant_o),
      .busy_o      (busy_o)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: who owns the bus (-1 = nobody), where the next
   // search starts, beats taken in the current burst, last granted index.
   int owner = -1;
   int m_ptr = 0;
   int m_cnt = 0;
   int m_tag = 0;

   // Source side: running beat index and burst length (0 = never last).
   int bi[NREQ];
   int blen[NREQ];

   // Observations taken from the DUT outputs.
   int obs_beats[NREQ];
   int gq[$];
   logic [NREQ-1:0] prev_grant;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Called just after a negedge with the inputs already set; returns at
   // the following negedge.
   task automatic cycle();
      logic [NREQ-1:0] e_grant, e_rr;
      logic            e_pv;
      logic [DW-1:0]   e_pd;
      int              s, idx;
      bit              end_b;
      for (int k = 0; k < NREQ; k++) begin
         req_data[k*DW +: DW] = {2'(k), 16'(bi[k])};
         req_last[k] = (blen[k] != 0) && ((bi[k] % blen[k]) == blen[k] - 1);
      end
      #1;
      e_grant = (owner >= 0) ? NREQ'(1 << owner) : '0;
      e_pv    = (owner >= 0) && req_valid[owner];
      e_pd    = (owner >= 0) ? {2'(owner), 16'(bi[owner])} : '0;
      e_rr    = (owner >= 0 && pad_ready) ? e_grant : '0;
      if (chk_en) begin
         check("grant",     32'(grant_o),     32'(e_grant));
         check("tag",       32'(pad_tag_o),   32'(m_tag));
         check("busy",      32'(busy_o),      32'(owner >= 0));
         check("pad_valid", 32'(pad_valid_o), 32'(e_pv));
         check("pad_data",  32'(pad_data_o),  32'(e_pd));
         check("req_ready", 32'(req_ready_o), 32'(e_rr));
      end
      if (grant_o != '0 && prev_grant == '0)
         for (int k = 0; k < NREQ; k++) if (grant_o[k]) gq.push_back(k);
      prev_grant = grant_o;
      if (!rst && pad_valid_o && pad_ready) obs_beats[pad_tag_o]++;
      // advance the model to the state after the coming edge
      if (rst) begin
         owner = -1; m_ptr = 0; m_cnt = 0; m_tag = 0;
      end else if (owner < 0) begin
`ifdef ZIGBEE_PAD_ARB_FIXED_PRIO_EN
         s = 0;
`else
         s = m_ptr;
`endif
         for (int i = 0; i < NREQ; i++) begin
            idx = (s + i) % NREQ;
            if (owner < 0 && req_valid[idx]) begin
               owner = idx; m_tag = idx; m_cnt = 0;
            end
         end
      end else if (e_pv && pad_ready) begin
         m_cnt++;
         end_b = req_last[owner] || (m_cnt == BM);
         bi[owner]++;
         if (end_b) begin
            m_ptr = (owner + 1) % NREQ;
            owner = -1;
            m_cnt = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst = 1'b1; req_valid = '0; pad_ready = 1'b0;
      cycle();
      rst = 1'b0;
      gq.delete();
      for (int k = 0; k < NREQ; k++) begin
         bi[k] = 0; blen[k] = 0; obs_beats[k] = 0;
      end
   endtask

   initial begin
      int exp3[5];
      int exp6[4];
`ifdef ZIGBEE_PAD_ARB_FIXED_PRIO_EN
      exp3 = '{0, 0, 0, 0, 0};
      exp6 = '{0, 0, 0, 0};
`else
      exp3 = '{0, 1, 2, 3, 0};
      exp6 = '{0, 3, 0, 3};
`endif
      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; pad_ready = 1'b0;
      for (int k = 0; k < NREQ; k++) begin bi[k] = 0; blen[k] = 0; obs_beats[k] = 0; end
      @(negedge clk);
      cycle();
      chk_en = 1'b1;
      reset_dut();

      // idle, no requests: everything stays zero
      repeat (10) cycle();

      // reset during a burst aborts it at the next edge
      req_valid = 4'b0001; pad_ready = 1'b1;
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0; req_valid = '0;
      check("rst_mid_busy",  32'(busy_o),  32'd0);
      check("rst_mid_grant", 32'(grant_o), 32'd0);
      cycle();

      // requester 2: 3 beats, last on the third
      reset_dut();
      blen[2] = 3; req_valid = 4'b0100; pad_ready = 1'b1;
      cycle();
      check("t2_grant", 32'(grant_o),   32'h4);
      check("t2_tag",   32'(pad_tag_o), 32'd2);
      repeat (3) cycle();
      req_valid = '0;
      check("t2_grant_end", 32'(grant_o), 32'd0);
      check("t2_beats",     32'(obs_beats[2]), 32'd3);
      repeat (2) cycle();

      // all four requesters, 2-beat bursts
      reset_dut();
      for (int k = 0; k < NREQ; k++) blen[k] = 2;
      req_valid = 4'b1111; pad_ready = 1'b1;
      repeat (16) cycle();
      check("t3_count", 32'(gq.size() >= 5), 32'd1);
      if (gq.size() >= 5)
         for (int i = 0; i < 5; i++) check("t3_order", 32'(gq[i]), 32'(exp3[i]));

      // requester 1 streams without last; requester 3 waits
      reset_dut();
      blen[3] = 1; req_valid = 4'b1010; pad_ready = 1'b1;
      repeat (11) cycle();
      check("t4_beats", 32'(obs_beats[1]), 32'd8);
      check("t4_count", 32'(gq.size() >= 2), 32'd1);
      if (gq.size() >= 2) begin
         check("t4_first", 32'(gq[0]), 32'd1);
`ifdef ZIGBEE_PAD_ARB_FIXED_PRIO_EN
         check("t4_next", 32'(gq[1]), 32'd1);
`else
         check("t4_next", 32'(gq[1]), 32'd3);
`endif
      end

      // pad_ready toggling 1,0,0,1 inside a burst
      reset_dut();
      req_valid = 4'b0001; pad_ready = 1'b1;
      cycle();
      pad_ready = 1'b1; cycle();
      pad_ready = 1'b0; cycle();
      pad_ready = 1'b0; cycle();
      pad_ready = 1'b1; cycle();
      check("t5_beats", 32'(obs_beats[0]), 32'd2);

      // requesters 0 and 3 contending
      reset_dut();
      blen[0] = 2; blen[3] = 2; req_valid = 4'b1001; pad_ready = 1'b1;
      repeat (13) cycle();
      check("t6_count", 32'(gq.size() >= 4), 32'd1);
      if (gq.size() >= 4)
         for (int i = 0; i < 4; i++) check("t6_order", 32'(gq[i]), 32'(exp6[i]));

      // randomized traffic against the model
      reset_dut();
      for (int k = 0; k < NREQ; k++) blen[k] = $urandom_range(0, 5);
      repeat (400) begin
         req_valid = 4'($urandom);
         pad_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 60) == 0);
         cycle();
      end
      rst = 1'b0;
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
